// File: rtl/scaler_cfg_ctrl_if.sv
// rtl/scaler_cfg_ctrl_if.sv - software configuration bus for scaler_cfg_ctrl
//
// Purpose: groups the configuration write request (steps, line size, auto
// flag, write strobe) with its status returns (pending, applied, error).
// Ports (signals):
//   cfg_h_step_i, cfg_v_step_i  requested scale steps (master -> slave)
//   cfg_inline_size_i           requested input line size minus 1
//   cfg_auto_size_i             derive line size from measured width
//   cfg_wr_i                    one-cycle write strobe
//   cfg_pending_o               shadow written, not yet applied (slave -> master)
//   cfg_applied_o               one-cycle pulse when scaler registers update
//   cfg_err_o                   one-cycle pulse when a write is rejected
interface scaler_cfg_ctrl_if #(
    parameter int STEP_WIDTH = 16
);
    logic [STEP_WIDTH-1:0] cfg_h_step_i;
    logic [STEP_WIDTH-1:0] cfg_v_step_i;
    logic [STEP_WIDTH-1:0] cfg_inline_size_i;
    logic                  cfg_auto_size_i;
    logic                  cfg_wr_i;
    logic                  cfg_pending_o;
    logic                  cfg_applied_o;
    logic                  cfg_err_o;

    modport master (
        output cfg_h_step_i, cfg_v_step_i, cfg_inline_size_i, cfg_auto_size_i, cfg_wr_i,
        input  cfg_pending_o, cfg_applied_o, cfg_err_o
    );

    modport slave (
        input  cfg_h_step_i, cfg_v_step_i, cfg_inline_size_i, cfg_auto_size_i, cfg_wr_i,
        output cfg_pending_o, cfg_applied_o, cfg_err_o
    );
endinterface

// File: rtl/scaler_cfg_ctrl.sv
// rtl/scaler_cfg_ctrl.sv - frame-synchronous configuration controller for the bilinear scaler
//
// Purpose: holds software writes in shadow registers and moves them to the
// scaler's reg_* inputs only during vertical blanking; measures input frame
// geometry; gates video until the first frame boundary after reset.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg                        configuration bus (slave side)
//   de_i, hs_i, vs_i           input video timing (hs high = line blank, vs high = active)
//   vid_en_o                   gate for de/hs/vs into the scaler
//   reg_h_scale_step_o         horizontal step to scaler
//   reg_v_scale_step_o         vertical step to scaler
//   reg_v_scale_inline_size_o  input line size minus 1 to scaler
//   meas_width_o               de count of the last line of the previous frame
//   meas_lines_o               active line count of the previous frame
module scaler_cfg_ctrl #(
    parameter int SCALE_STEP = 128,
    parameter int STEP_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    scaler_cfg_ctrl_if.slave      cfg,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic                  vid_en_o,
    output logic [STEP_WIDTH-1:0] reg_h_scale_step_o,
    output logic [STEP_WIDTH-1:0] reg_v_scale_step_o,
    output logic [STEP_WIDTH-1:0] reg_v_scale_inline_size_o,
    output logic [CNT_WIDTH-1:0]  meas_width_o,
    output logic [CNT_WIDTH-1:0]  meas_lines_o
);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_BLANK,
        ST_ACTIVE
    } state_t;

    state_t state_q, state_d;

    logic [STEP_WIDTH-1:0] sh_h_q, sh_v_q, sh_inline_q;
    logic                  sh_auto_q;
    logic                  pending_q, applied_q, err_q, vid_en_q;
    logic [STEP_WIDTH-1:0] h_q, v_q, inline_q, inline_d;
    logic [CNT_WIDTH-1:0]  pix_q, line_q, width_run_q, meas_width_q, meas_lines_q;
    logic                  hs_prev_q;

    logic wr_ok, wr_bad, apply, enter_active, leave_active, hs_rise;

    assign wr_ok        = cfg.cfg_wr_i && (cfg.cfg_h_step_i != '0) && (cfg.cfg_v_step_i != '0);
    assign wr_bad       = cfg.cfg_wr_i && !wr_ok;
    // A write in the same cycle as an apply opportunity defers the apply so
    // the freshly written values are the ones that land.
    assign apply        = (state_q == ST_BLANK) && pending_q && !cfg.cfg_wr_i;
    assign enter_active = (state_q == ST_BLANK) && vs_i;
    assign leave_active = (state_q == ST_ACTIVE) && !vs_i;
    assign hs_rise      = hs_i && !hs_prev_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC:   if (!vs_i) state_d = ST_BLANK;
            ST_BLANK:  if (vs_i)  state_d = ST_ACTIVE;
            ST_ACTIVE: if (!vs_i) state_d = ST_BLANK;
            default:   state_d = ST_SYNC;
        endcase
    end

    // Auto mode tracks the measured width; a zero width (no counted line)
    // keeps whatever size the scaler already has.
    always_comb begin
        inline_d = sh_inline_q;
        if (sh_auto_q) begin
            if (meas_width_q != '0) begin
                inline_d = STEP_WIDTH'(meas_width_q - CNT_WIDTH'(1));
            end else begin
                inline_d = inline_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SYNC;
            vid_en_q     <= 1'b0;
            sh_h_q       <= STEP_WIDTH'(SCALE_STEP);
            sh_v_q       <= STEP_WIDTH'(SCALE_STEP);
            sh_inline_q  <= '0;
            sh_auto_q    <= 1'b0;
            pending_q    <= 1'b0;
            applied_q    <= 1'b0;
            err_q        <= 1'b0;
            h_q          <= STEP_WIDTH'(SCALE_STEP);
            v_q          <= STEP_WIDTH'(SCALE_STEP);
            inline_q     <= '0;
            pix_q        <= '0;
            line_q       <= '0;
            width_run_q  <= '0;
            meas_width_q <= '0;
            meas_lines_q <= '0;
            hs_prev_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vid_en_q  <= (state_d != ST_SYNC);
            hs_prev_q <= hs_i;
            err_q     <= wr_bad;
            applied_q <= apply;

            if (wr_ok) begin
                sh_h_q      <= cfg.cfg_h_step_i;
                sh_v_q      <= cfg.cfg_v_step_i;
                sh_inline_q <= cfg.cfg_inline_size_i;
                sh_auto_q   <= cfg.cfg_auto_size_i;
                pending_q   <= 1'b1;
            end else if (apply) begin
                pending_q <= 1'b0;
            end else if (sh_auto_q && leave_active && (width_run_q != meas_width_q)) begin
                pending_q <= 1'b1;
            end

            if (apply) begin
                h_q      <= sh_h_q;
                v_q      <= sh_v_q;
                inline_q <= inline_d;
            end

            if (enter_active) begin
                pix_q  <= '0;
                line_q <= '0;
            end else if (state_q == ST_ACTIVE) begin
                if (hs_i) begin
                    pix_q <= '0;
                end else if (de_i && (pix_q != '1)) begin
                    pix_q <= pix_q + CNT_WIDTH'(1);
                end
                // Lines without any de are not counted and do not touch width.
                if (hs_rise && (pix_q != '0)) begin
                    width_run_q <= pix_q;
                    if (line_q != '1) begin
                        line_q <= line_q + CNT_WIDTH'(1);
                    end
                end
                if (leave_active) begin
                    meas_width_q <= width_run_q;
                    meas_lines_q <= line_q;
                end
            end
        end
    end

    assign cfg.cfg_pending_o  = pending_q;
    assign cfg.cfg_applied_o  = applied_q;
    assign cfg.cfg_err_o      = err_q;
    assign vid_en_o                  = vid_en_q;
    assign reg_h_scale_step_o        = h_q;
    assign reg_v_scale_step_o        = v_q;
    assign reg_v_scale_inline_size_o = inline_q;
    assign meas_width_o              = meas_width_q;
    assign meas_lines_o              = meas_lines_q;

endmodule
